// File: rtl/instr_encoder_if.sv
// Descriptor stream in, instruction-memory write port and session status out.
// err_range exists only when INSTR_ENC_RANGE_CHECK_EN is defined.
interface instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [3:0]        in_class;
  logic [2:0]        in_funct_sel;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [31:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wd;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;
  logic              err_illegal;
  logic              err_full;
`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic              err_range;
`endif

  modport master (
    output start, in_valid, in_last, in_class, in_funct_sel,
           in_rs, in_rt, in_rd, in_imm, in_target,
    input  in_ready, imem_we, imem_addr, imem_wd, busy, done, count,
`ifdef INSTR_ENC_RANGE_CHECK_EN
           err_range,
`endif
           err_illegal, err_full
  );

  modport slave (
    input  start, in_valid, in_last, in_class, in_funct_sel,
           in_rs, in_rt, in_rd, in_imm, in_target,
    output in_ready, imem_we, imem_addr, imem_wd, busy, done, count,
`ifdef INSTR_ENC_RANGE_CHECK_EN
           err_range,
`endif
           err_illegal, err_full
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes instruction descriptors into MIPS words written sequentially to imem.
// Latency: accepted beat appears on imem_we/addr/wd one cycle later, full rate.
// Backpressure: in_ready low outside LOAD, during start, or once memory is full.
// Optional: INSTR_ENC_RANGE_CHECK_EN adds the sticky err_range immediate check.
module instr_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wd_q;
  logic              busy_q, done_q;
  logic              err_illegal_q, err_full_q;

  logic              in_ready;
  logic              accept;
  logic              legal;
  logic [31:0]       word;
  logic [5:0]        funct;
  logic              chk_signed;
  logic              chk_unsigned;

  // Count never exceeds 2^ADDR_W, so its MSB alone flags a full memory.
  assign in_ready = (state_q == LOAD) && !bus.start && !count_q[ADDR_W];
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    legal        = 1'b1;
    word         = '0;
    funct        = 6'b000000;
    chk_signed   = 1'b0;
    chk_unsigned = 1'b0;
    case (bus.in_funct_sel)
      3'd0:    funct = 6'b100000;
      3'd1:    funct = 6'b100010;
      3'd2:    funct = 6'b100100;
      3'd3:    funct = 6'b100101;
      3'd4:    funct = 6'b101010;
      default: funct = 6'b000000;
    endcase
    case (bus.in_class)
      4'd0: begin
        legal = (bus.in_funct_sel <= 3'd4);
        word  = {OP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, funct};
      end
      4'd1: begin
        word       = {OP_LW, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
        chk_signed = 1'b1;
      end
      4'd2: begin
        word       = {OP_SW, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
        chk_signed = 1'b1;
      end
      4'd3: begin
        word       = {OP_BEQ, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
        chk_signed = 1'b1;
      end
      4'd4: begin
        word       = {OP_ADDI, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
        chk_signed = 1'b1;
      end
      4'd5: word = {OP_J, bus.in_target};
      4'd6: begin
        word         = {OP_ANDI, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
        chk_unsigned = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic err_range_q;
  logic range_bad;
  logic fits_s16;
  logic fits_u16;

  assign fits_s16  = (&bus.in_imm[31:15]) || !(|bus.in_imm[31:15]);
  assign fits_u16  = !(|bus.in_imm[31:16]);
  assign range_bad = (chk_signed && !fits_s16) || (chk_unsigned && !fits_u16);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_range_q <= 1'b0;
    end else if (bus.start) begin
      err_range_q <= 1'b0;
    end else if (accept && legal && range_bad) begin
      err_range_q <= 1'b1;
    end
  end

  assign bus.err_range = err_range_q;
`else
  // Without the range check the upper immediate bits are simply truncated.
  logic unused_imm_hi;
  assign unused_imm_hi = ^{bus.in_imm[31:16], chk_signed, chk_unsigned};
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        if (bus.start) begin
          state_d = LOAD;
        end else if (accept && (bus.in_last || (legal && count_q == LAST_CNT))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= BASE_PTR;
      count_q       <= '0;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wd_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_illegal_q <= 1'b0;
      err_full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d == LOAD);
      done_q    <= (state_d == DONE);
      imem_we_q <= 1'b0;
      if (bus.start) begin
        ptr_q         <= BASE_PTR;
        count_q       <= '0;
        err_illegal_q <= 1'b0;
        err_full_q    <= 1'b0;
      end else if (accept) begin
        if (legal) begin
          imem_we_q   <= 1'b1;
          imem_addr_q <= ptr_q;
          imem_wd_q   <= word;
          ptr_q       <= ptr_q + 1'b1;
          count_q     <= count_q + 1'b1;
          if (count_q == LAST_CNT && !bus.in_last) err_full_q <= 1'b1;
        end else begin
          err_illegal_q <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.imem_we     = imem_we_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.imem_wd     = imem_wd_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.count       = count_q;
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_full    = err_full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench: table of descriptor beats on a 64-word encoder, plus
// hand sequences for fill-up, restart, async reset and the range check.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(6)) ifa ();
  instr_encoder_if #(.ADDR_W(2)) ifb ();

  instr_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  typedef struct {
    logic        start;
    logic [3:0]  cls;
    logic [2:0]  fs;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [25:0] tgt;
    logic        last;
    logic        e_we;
    logic [5:0]  e_addr;
    logic [31:0] e_wd;
    logic [6:0]  e_count;
    logic        e_done;
    logic        e_ill;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic st, input logic [3:0] c, input logic [2:0] f,
                              input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                              input logic [31:0] im, input logic [25:0] tg, input logic l,
                              input logic we, input logic [5:0] a, input logic [31:0] wd,
                              input logic [6:0] cnt, input logic dn, input logic il);
    vec_t v;
    v.start = st; v.cls = c; v.fs = f; v.rs = s; v.rt = t; v.rd = d;
    v.imm = im; v.tgt = tg; v.last = l; v.e_we = we; v.e_addr = a;
    v.e_wd = wd; v.e_count = cnt; v.e_done = dn; v.e_ill = il;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic start_a();
    @(negedge clk);
    ifa.start = 1'b1;
    ifa.in_valid = 1'b0;
    @(posedge clk);
    #1 ifa.start = 1'b0;
    check("a_start_busy", ifa.busy, 1);
    check("a_start_count", ifa.count, 0);
  endtask

  task automatic start_b();
    @(negedge clk);
    ifb.start = 1'b1;
    @(posedge clk);
    #1 ifb.start = 1'b0;
  endtask

  task automatic beat_a(input logic [3:0] c, input logic [4:0] t, input logic [31:0] im, input logic l);
    @(negedge clk);
    ifa.in_class = c; ifa.in_funct_sel = 3'd0; ifa.in_rs = 5'd0; ifa.in_rt = t;
    ifa.in_rd = 5'd0; ifa.in_imm = im; ifa.in_target = '0; ifa.in_last = l;
    ifa.in_valid = 1'b1;
    @(posedge clk);
    #1 ifa.in_valid = 1'b0;
    ifa.in_last = 1'b0;
  endtask

  task automatic beat_b(input int k, input logic l);
    @(negedge clk);
    ifb.in_class = 4'd4; ifb.in_rs = 5'd0; ifb.in_rt = 5'(k);
    ifb.in_imm = 32'(k); ifb.in_last = l; ifb.in_valid = 1'b1;
    @(posedge clk);
    #1 ifb.in_valid = 1'b0;
    ifb.in_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b_wd[4];
    b_wd[0] = 32'h20000000; b_wd[1] = 32'h20010001;
    b_wd[2] = 32'h20020002; b_wd[3] = 32'h20030003;

    vecs[0]  = mk(1, 4, 0, 0, 2, 0, 32'd5, 0, 0,        1, 0, 32'h20020005, 1, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 3, 0, 32'd8, 0, 0,        1, 1, 32'h8C030008, 2, 0, 0);
    vecs[2]  = mk(0, 5, 0, 0, 0, 0, 0, 26'h11, 1,       1, 2, 32'h08000011, 3, 1, 0);
    vecs[3]  = mk(1, 0, 0, 2, 3, 4, 0, 0, 0,            1, 0, 32'h00432020, 1, 0, 0);
    vecs[4]  = mk(0, 3, 0, 4, 4, 0, 32'hFFFF, 0, 1,     1, 1, 32'h1084FFFF, 2, 1, 0);
    vecs[5]  = mk(1, 9, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 1);
    vecs[6]  = mk(0, 6, 0, 1, 1, 0, 32'h00FF, 0, 1,     1, 0, 32'h302100FF, 1, 1, 1);
    vecs[7]  = mk(1, 0, 1, 1, 2, 3, 0, 0, 0,            1, 0, 32'h00221822, 1, 0, 0);
    vecs[8]  = mk(0, 0, 2, 5, 6, 7, 0, 0, 0,            1, 1, 32'h00A63824, 2, 0, 0);
    vecs[9]  = mk(0, 0, 3, 8, 9, 10, 0, 0, 0,           1, 2, 32'h01095025, 3, 0, 0);
    vecs[10] = mk(0, 0, 4, 31, 31, 31, 0, 0, 0,         1, 3, 32'h03FFF82A, 4, 0, 0);
    vecs[11] = mk(0, 2, 0, 29, 31, 0, 32'hFFFFFFFC, 0, 0, 1, 4, 32'hAFBFFFFC, 5, 0, 0);
    vecs[12] = mk(0, 0, 5, 1, 1, 1, 0, 0, 1,            0, 0, 0,            5, 1, 1);

    reset = 1'b1;
    ifa.start = 0; ifa.in_valid = 0; ifa.in_last = 0; ifa.in_class = 0; ifa.in_funct_sel = 0;
    ifa.in_rs = 0; ifa.in_rt = 0; ifa.in_rd = 0; ifa.in_imm = 0; ifa.in_target = 0;
    ifb.start = 0; ifb.in_valid = 0; ifb.in_last = 0; ifb.in_class = 0; ifb.in_funct_sel = 0;
    ifb.in_rs = 0; ifb.in_rt = 0; ifb.in_rd = 0; ifb.in_imm = 0; ifb.in_target = 0;
    #1;
    check("rst_we", ifa.imem_we, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_done", ifa.done, 0);
    check("rst_count", ifa.count, 0);
    check("rst_ready", ifa.in_ready, 0);
    check("rst_errs", {ifa.err_illegal, ifa.err_full}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Table-driven sessions on the 64-word encoder.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].start) start_a();
      @(negedge clk);
      ifa.in_class = vecs[i].cls; ifa.in_funct_sel = vecs[i].fs;
      ifa.in_rs = vecs[i].rs; ifa.in_rt = vecs[i].rt; ifa.in_rd = vecs[i].rd;
      ifa.in_imm = vecs[i].imm; ifa.in_target = vecs[i].tgt; ifa.in_last = vecs[i].last;
      ifa.in_valid = 1'b1;
      @(posedge clk);
      #1 ifa.in_valid = 1'b0;
      ifa.in_last = 1'b0;
      check($sformatf("v%0d_we", i), ifa.imem_we, vecs[i].e_we);
      if (vecs[i].e_we) begin
        check($sformatf("v%0d_addr", i), ifa.imem_addr, vecs[i].e_addr);
        check($sformatf("v%0d_wd", i), ifa.imem_wd, vecs[i].e_wd);
      end
      check($sformatf("v%0d_count", i), ifa.count, vecs[i].e_count);
      check($sformatf("v%0d_done", i), ifa.done, vecs[i].e_done);
      check($sformatf("v%0d_ill", i), ifa.err_illegal, vecs[i].e_ill);
      check($sformatf("v%0d_full", i), ifa.err_full, 0);
    end

    // Four-word memory: fill without in_last, fifth beat must stall.
    start_b();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        @(negedge clk);
        ifb.in_valid = 1'b1;
        #1 check("b_fifth_ready", ifb.in_ready, 0);
      end
      beat_b(k, 1'b0);
      if (k < 4) begin
        check($sformatf("b%0d_we", k), ifb.imem_we, 1);
        check($sformatf("b%0d_addr", k), ifb.imem_addr, k);
        check($sformatf("b%0d_wd", k), ifb.imem_wd, b_wd[k]);
      end else begin
        check("b4_we", ifb.imem_we, 0);
      end
      if (k == 2) check("b2_done", ifb.done, 0);
      if (k == 3) begin
        check("b3_done", ifb.done, 1);
        check("b3_full", ifb.err_full, 1);
      end
    end
    check("b_count", ifb.count, 4);

    // Final slot carrying in_last is a clean finish.
    start_b();
    check("b_restart_full", ifb.err_full, 0);
    for (int k = 0; k < 4; k++) beat_b(k, k == 3);
    check("b_last_done", ifb.done, 1);
    check("b_last_full", ifb.err_full, 0);
    check("b_last_count", ifb.count, 4);

    // Restart with a same-cycle beat, then async reset between edges.
    start_a();
    beat_a(4'd4, 5'd1, 32'd1, 1'b0);
    check("r_first_count", ifa.count, 1);
    @(negedge clk);
    ifa.in_class = 4'd4; ifa.in_rt = 5'd7; ifa.in_imm = 32'd7;
    ifa.in_valid = 1'b1; ifa.start = 1'b1;
    #1 check("r_ready_on_start", ifa.in_ready, 0);
    @(posedge clk);
    #1 ifa.start = 1'b0;
    ifa.in_valid = 1'b0;
    check("r_restart_we", ifa.imem_we, 0);
    check("r_restart_count", ifa.count, 0);
    check("r_restart_busy", ifa.busy, 1);
    beat_a(4'd4, 5'd2, 32'd2, 1'b0);
    check("r_ptr_we", ifa.imem_we, 1);
    check("r_ptr_addr", ifa.imem_addr, 0);
    check("r_ptr_wd", ifa.imem_wd, 32'h20020002);
    #2 reset = 1'b1;
    #1;
    check("ar_we", ifa.imem_we, 0);
    check("ar_busy", ifa.busy, 0);
    check("ar_count", ifa.count, 0);
    check("ar_wd", ifa.imem_wd, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 check("ar_idle_ready", ifa.in_ready, 0);
    check("ar_idle_busy", ifa.busy, 0);

`ifdef INSTR_ENC_RANGE_CHECK_EN
    start_a();
    beat_a(4'd4, 5'd0, 32'd40000, 1'b0);
    check("rg_addi_wd", ifa.imem_wd, 32'h20009C40);
    check("rg_addi_flag", ifa.err_range, 1);
    start_a();
    check("rg_cleared", ifa.err_range, 0);
    beat_a(4'd6, 5'd0, 32'd40000, 1'b0);
    check("rg_andi_wd", ifa.imem_wd, 32'h30009C40);
    check("rg_andi_flag", ifa.err_range, 0);
    beat_a(4'd6, 5'd0, 32'h00010000, 1'b0);
    check("rg_andi_big", ifa.err_range, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes a stream of instruction descriptors into 32-bit MIPS machine words and writes them sequentially into instruction memory.
- Acts as the program loader on the opposite side of the main decoder: it produces the opcodes and fields that the datapath decodes.
- Supports R-type (add/sub/and/or/slt), LW, SW, BEQ, ADDI, J and ANDI.
- Descriptor input uses a valid/ready handshake. Output is a registered memory write port.

Parameters:
- ADDR_W, 6: instruction-memory word-address width. Capacity is 2^ADDR_W words.
- BASE_ADDR, 0: word address of the first write after start.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins or restarts a load session
- in_valid  in  1  descriptor valid
- in_ready  out  1  encoder can accept a descriptor this cycle
- in_last  in  1  descriptor is the final one of the program
- in_class  in  4  0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6 ANDI; 7-15 illegal
- in_funct_sel  in  3  RTYPE only: 0 add, 1 sub, 2 and, 3 or, 4 slt; 5-7 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  32  immediate; low 16 bits are encoded
- in_target  in  26  J target field
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wd  out  32  encoded instruction word
- busy  out  1  high in LOAD
- done  out  1  high in DONE
- count  out  ADDR_W+1  words written in the current session
- err_illegal  out  1  sticky: an illegal class or funct was dropped
- err_full  out  1  sticky: memory filled before in_last was seen

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; write pointer = BASE_ADDR.
- FSM states IDLE, LOAD, DONE.
  - IDLE --start--> LOAD.
  - LOAD --(accepted beat with in_last) or (write of final slot)--> DONE.
  - DONE --start--> LOAD.
  - start in LOAD restarts the session. Restart has priority over a same-cycle beat; that beat is not accepted.
- Session start: clears count, err_illegal and err_full, and sets the pointer to BASE_ADDR.
- in_ready = (state==LOAD) && !start && (count < 2^ADDR_W). A beat is accepted when in_valid && in_ready.
- Latency: a beat accepted on edge N drives imem_we=1 with imem_addr/imem_wd during the cycle after edge N. imem_we is low otherwise. One write per cycle is sustainable at full throughput.
- Encodings:
  - RTYPE: {6'b000000, rs, rt, rd, 5'b0, funct}. funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - I-type: {op, rs, rt, imm[15:0]}. op: LW 100011, SW 101011, BEQ 000100, ADDI 001000, ANDI 001100.
  - J: {6'b000010, target}.
- Illegal class or funct:
  - The beat is accepted and dropped: no write, pointer and count unchanged, err_illegal set.
  - in_last on an illegal beat still moves the FSM to DONE.
- Pointer and count increment on every write. The pointer wraps modulo 2^ADDR_W, which is only relevant when BASE_ADDR≠0.
- Full: when count reaches 2^ADDR_W without in_last, the FSM goes to DONE and err_full is set. If the final slot's beat carries in_last, err_full stays 0.
- done and busy are registered state decodes.
- Reset mid-session aborts immediately. No pending write is issued.

Optional Feature:
- Macro: INSTR_ENC_RANGE_CHECK_EN.
- When defined:
  - Adds output err_range (1 bit, sticky, cleared on session start and on reset).
  - err_range is set when a legal beat's in_imm does not fit 16 bits: signed range -32768..32767 for LW/SW/BEQ/ADDI; unsigned range 0..65535 for ANDI.
  - The word is still written, truncated to the low 16 bits.
- When undefined: no err_range port and no comparators; truncation is silent.

Test Plan:
- Reset, then start. Beats: ADDI rs=0 rt=2 imm=5; LW rs=0 rt=3 imm=8; J target=0x0000011 with in_last -> writes 0x20020005@0, 0x8C030008@1, 0x08000011@2; count=3, done=1, err flags 0.
- RTYPE funct_sel=0 rs=2 rt=3 rd=4, then BEQ rs=4 rt=4 imm=0xFFFF (in_last) -> 0x00432020@0, 0x1084FFFF@1.
- Beat class=9, then ANDI rs=1 rt=1 imm=0x00FF -> no write for the first beat; 0x302100FF written @0; err_illegal=1; count=1.
- ADDR_W=2: five beats, no in_last -> four writes @0-3; DONE after the fourth; in_ready=0 for the fifth; err_full=1.
- Start pulse with a same-cycle valid beat mid-session, and async reset asserted between edges -> beat not accepted, count=0, pointer=BASE_ADDR; reset forces IDLE with all outputs 0 immediately.
- INSTR_ENC_RANGE_CHECK_EN: ADDI imm=40000 -> 0x20009C40 written, err_range=1; ANDI imm=40000 -> err_range stays 0.
